// File: rtl/sd_pkg.sv
// Shared sigma-delta definitions: bit-to-level mapping, CIC order, and the
// CIC integrator width function. Used by the encoder and decoder sides.
package sd_pkg;

  localparam int SD_IN_BW_DEFAULT = 16;
  localparam int CIC_ORDER        = 3;

  // A stream bit of 1 stands for +1, a bit of 0 stands for -1.
  localparam int SD_BIT_ONE  = 1;
  localparam int SD_BIT_ZERO = -1;

  typedef enum logic [1:0] {
    WARM0,
    WARM1,
    WARM2,
    RUN
  } warm_state_t;

  function automatic int cic_w(input int decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

endpackage

// File: rtl/sd_cic3.sv
// Single-channel third-order CIC decimator: wrap-around integrators, a 3-stage
// registered comb (differential delay 1) and truncating scale with saturation.
module sd_cic3
  import sd_pkg::*;
#(
  parameter int DATA_W     = SD_IN_BW_DEFAULT,
  parameter int DECIM_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     stb,
  input  logic                     sd_bit,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     vld
);

  localparam int W     = cic_w(DECIM_LOG2);
  localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - DATA_W + 1;

  localparam logic signed [W-1:0] X_POS   = W'(SD_BIT_ONE);
  localparam logic signed [W-1:0] X_NEG   = W'(SD_BIT_ZERO);
  localparam logic signed [W-1:0] OUT_MAX = W'((1 << (DATA_W - 1)) - 1);

  // Full-scale positive input lands exactly one LSB above the output range.
  function automatic logic signed [DATA_W-1:0] scale_sat(input logic signed [W-1:0] c);
    logic signed [W-1:0] s;
    s = c >>> SHIFT;
    if (s > OUT_MAX) s = OUT_MAX;
    return DATA_W'(s);
  endfunction

  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, i3;
  logic signed [W-1:0] i1_n, i2_n, i3_n;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1_p0, c2_p1, c3_p2;
  logic                vld_p0, vld_p1, vld_p2;

  assign x = sd_bit ? X_POS : X_NEG;

  always_comb begin
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1     <= '0;
      i2     <= '0;
      i3     <= '0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      c1_p0  <= '0;
      c2_p1  <= '0;
      c3_p2  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (en) begin
        i1 <= i1_n;
        i2 <= i2_n;
        i3 <= i3_n;
      end
      // p0: first comb stage, fed directly by the strobed integrator value
      vld_p0 <= stb;
      if (stb) begin
        c1_p0 <= i3_n - d1;
        d1    <= i3_n;
      end
      // p1: second comb stage
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        c2_p1 <= c1_p0 - d2;
        d2    <= c1_p0;
      end
      // p2: third comb stage
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        c3_p2 <= c2_p1 - d3;
        d3    <= c2_p1;
      end
    end
  end

  assign out_data = scale_sat(c3_p2);
  assign vld      = vld_p2;

endmodule

// File: rtl/sd_quad_decim.sv
// Quadrature sigma-delta decoder: two lockstep CIC3 channels, warm-up FSM and
// a 2-entry output FIFO. SD_QUAD_DECIM_OVR_CNT_EN adds a dropped-pair counter.
module sd_quad_decim
  import sd_pkg::*;
#(
  parameter int SD_IN_BW   = SD_IN_BW_DEFAULT,
  parameter int DECIM_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bs_en,
  input  logic                       sin,
  input  logic                       cos,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SD_IN_BW-1:0] out_sin,
  output logic signed [SD_IN_BW-1:0] out_cos,
`ifdef SD_QUAD_DECIM_OVR_CNT_EN
  output logic [7:0]                 ovr_cnt,
`endif
  output logic                       overrun
);

  logic [DECIM_LOG2-1:0] cnt;
  logic                  stb;

  assign stb = bs_en & (cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (bs_en) cnt <= cnt + 1'b1;
  end

  logic signed [SD_IN_BW-1:0] res_sin, res_cos;
  logic                       sin_vld, cos_vld, res_vld;

  sd_cic3 #(.DATA_W(SD_IN_BW), .DECIM_LOG2(DECIM_LOG2)) u_cic_sin (
    .clk(clk), .rst(rst), .en(bs_en), .stb(stb), .sd_bit(sin),
    .out_data(res_sin), .vld(sin_vld)
  );

  sd_cic3 #(.DATA_W(SD_IN_BW), .DECIM_LOG2(DECIM_LOG2)) u_cic_cos (
    .clk(clk), .rst(rst), .en(bs_en), .stb(stb), .sd_bit(cos),
    .out_data(res_cos), .vld(cos_vld)
  );

  assign res_vld = sin_vld & cos_vld;

  // Warm-up: the first three comb results carry the CIC fill transient.
  warm_state_t state_q, state_d;
  logic        push;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WARM0;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (res_vld) begin
      case (state_q)
        WARM0:   state_d = WARM1;
        WARM1:   state_d = WARM2;
        WARM2:   state_d = RUN;
        default: push = 1'b1;
      endcase
    end
  end

  logic signed [SD_IN_BW-1:0] fifo_sin [2];
  logic signed [SD_IN_BW-1:0] fifo_cos [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;
  logic                       full, pop, wr, drop;

  assign out_valid = (count != 2'd0);
  assign full      = (count == 2'd2);
  assign pop       = out_valid & out_ready;
  assign wr        = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_sin   = fifo_sin[rd_ptr];
  assign out_cos   = fifo_cos[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_sin[i] <= '0;
        fifo_cos[i] <= '0;
      end
    end else begin
      if (wr) begin
        fifo_sin[wr_ptr] <= res_sin;
        fifo_cos[wr_ptr] <= res_cos;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SD_QUAD_DECIM_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) ovr_cnt <= 8'd0;
    else if (drop && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign overrun = (ovr_cnt != 8'd0);
`else
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else if (drop) ovr_q <= 1'b1;
  end

  assign overrun = ovr_q;
`endif

endmodule
